// File: rtl/trace_pkg.sv
// trace_pkg: retire trace record layout and sizing shared by the trace buffer
package trace_pkg;
   localparam int TRACE_DEPTH_DEFAULT = 16;
   localparam int TRACE_XLEN = 32;
   localparam int DROP_CNT_W = 16;
   typedef struct packed {
`ifdef RETIRE_TRACE_SEQ_EN
      logic [31:0]           seq;
`endif
      logic [TRACE_XLEN-1:0] pc;
      logic [31:0]           instruction;
      logic [TRACE_XLEN-1:0] alu_out;
      logic [TRACE_XLEN-1:0] wdata;
      logic [TRACE_XLEN-1:0] rdata;
      logic [TRACE_XLEN-1:0] next_pc;
      logic                  reg_wr;
      logic                  rd_en;
      logic                  wr_en;
      logic                  br_taken;
   } trace_rec_t;
endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: synchronous FIFO without bypass; caller only pushes when space exists or a pop is concurrent
module trace_fifo #(
   parameter int W = 8,
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   always_ff @(posedge clk)
      if (push && !reset) mem[wr_ptr] <= din;
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end
   assign dout  = mem[rd_ptr];
   assign empty = count == '0;
   assign full  = count == (AW+1)'(DEPTH);
endmodule

// File: rtl/retire_trace_buffer.sv
// retire_trace_buffer: snapshots retired instructions into a drop-on-full trace FIFO; RETIRE_TRACE_SEQ_EN adds a seq field
module retire_trace_buffer
   import trace_pkg::*;
#(
   parameter int DEPTH = TRACE_DEPTH_DEFAULT,
   parameter int XLEN = TRACE_XLEN,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   input  logic [XLEN-1:0]       in_pc,
   input  logic [31:0]           in_instruction,
   input  logic [XLEN-1:0]       in_alu_out,
   input  logic [XLEN-1:0]       in_wdata,
   input  logic [XLEN-1:0]       in_rdata,
   input  logic [XLEN-1:0]       in_next_pc,
   input  logic                  in_reg_wr,
   input  logic                  in_rd_en,
   input  logic                  in_wr_en,
   input  logic                  in_br_taken,
   output logic                  out_valid,
   input  logic                  out_ready,
   output trace_rec_t            out_record,
   output logic [AW:0]           occupancy,
   output logic                  overflow,
   output logic [DROP_CNT_W-1:0] drop_count
);
   trace_rec_t                     rec;
   logic [$bits(trace_rec_t)-1:0]  head;
   logic                           full, empty, pop, push, drop;
`ifdef RETIRE_TRACE_SEQ_EN
   logic [31:0] seq;
   always_ff @(posedge clk)
      seq <= reset ? '0 : seq + 32'(in_valid);
`endif
   always_comb begin
      rec = '0;
`ifdef RETIRE_TRACE_SEQ_EN
      rec.seq = seq;
`endif
      rec.pc          = in_pc;
      rec.instruction = in_instruction;
      rec.alu_out     = in_alu_out;
      rec.wdata       = in_wdata;
      rec.rdata       = in_rdata;
      rec.next_pc     = in_next_pc;
      rec.reg_wr      = in_reg_wr;
      rec.rd_en       = in_rd_en;
      rec.wr_en       = in_wr_en;
      rec.br_taken    = in_br_taken;
   end
   assign out_valid  = !empty;
   assign pop        = out_valid && out_ready;
   assign push       = in_valid && (!full || pop);
   assign drop       = in_valid && full && !pop;
   assign out_record = out_valid ? trace_rec_t'(head) : '0;
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end else if (drop) begin
         overflow   <= 1'b1;
         drop_count <= (drop_count == '1) ? drop_count : drop_count + DROP_CNT_W'(1);
      end
   end
   trace_fifo #(.W($bits(trace_rec_t)), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (rec),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (occupancy)
   );
endmodule

// File: tb/tb_retire_trace_buffer.sv
// tb_retire_trace_buffer: directed checks of push/pop/drop, wrap, reset and (with RETIRE_TRACE_SEQ_EN) seq/saturation
module tb_retire_trace_buffer;
   import trace_pkg::*;
   logic        clk = 0, reset = 1, in_valid = 0, out_ready = 0;
   logic [31:0] in_pc = 0, in_instruction = 0, in_alu_out = 0, in_wdata = 0, in_rdata = 0, in_next_pc = 0;
   logic        in_reg_wr = 0, in_rd_en = 0, in_wr_en = 0, in_br_taken = 0;
   logic        out_valid, overflow;
   trace_rec_t  out_record;
   logic [4:0]  occupancy;
   logic [15:0] drop_count;
   int          checks = 0, failures = 0;
   always #5 clk = ~clk;
   retire_trace_buffer dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_pc(in_pc), .in_instruction(in_instruction),
      .in_alu_out(in_alu_out), .in_wdata(in_wdata), .in_rdata(in_rdata), .in_next_pc(in_next_pc),
      .in_reg_wr(in_reg_wr), .in_rd_en(in_rd_en), .in_wr_en(in_wr_en), .in_br_taken(in_br_taken),
      .out_valid(out_valid), .out_ready(out_ready), .out_record(out_record),
      .occupancy(occupancy), .overflow(overflow), .drop_count(drop_count)
   );
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      reset = 1;
      tick();
      reset = 0;
   endtask
   task automatic push_n(input int n, input logic [31:0] base);
      in_valid = 1;
      for (int i = 0; i < n; i++) begin
         in_pc = base + 32'(4 * i);
         tick();
      end
      in_valid = 0;
   endtask
   initial begin
      logic [31:0] q[$];
      int drops;
      logic rdy, popped;
      tick();
      do_reset();
      check("rst_valid", out_valid, 0);
      check("rst_occ", occupancy, 0);
      check("rst_ovf", overflow, 0);
      check("rst_drop", drop_count, 0);
      check("rst_rec", out_record, 0);
      // single push with latency 1
      out_ready = 1;
      in_valid = 1; in_pc = 32'h100; in_instruction = 32'h00500093; in_br_taken = 1;
      tick();
      in_valid = 0;
      check("single_valid", out_valid, 1);
      check("single_pc", out_record.pc, 32'h100);
      check("single_instr", out_record.instruction, 32'h00500093);
      check("single_br", out_record.br_taken, 1);
      check("single_occ", occupancy, 1);
      tick();
      check("single_valid_after", out_valid, 0);
      check("single_occ_after", occupancy, 0);
      // back-pressure with 4 drops
      out_ready = 0;
      push_n(20, 32'h1000);
      check("bp_occ", occupancy, 16);
      check("bp_ovf", overflow, 1);
      check("bp_drop", drop_count, 4);
      check("bp_head_stable", out_record.pc, 32'h1000);
      out_ready = 1;
      for (int k = 0; k < 16; k++) begin
         check("bp_drain_pc", out_record.pc, 32'h1000 + 32'(4 * k));
         tick();
      end
      check("bp_empty", out_valid, 0);
      // full with concurrent push and pop
      out_ready = 0;
      push_n(16, 32'h2000);
      check("fp_full", occupancy, 16);
      in_valid = 1; in_pc = 32'h3000; out_ready = 1;
      tick();
      in_valid = 0;
      check("fp_occ", occupancy, 16);
      check("fp_drop", drop_count, 4);
      check("fp_head", out_record.pc, 32'h2004);
      for (int k = 0; k < 16; k++) begin
         check("fp_drain_pc", out_record.pc, (k < 15) ? 32'h2004 + 32'(4 * k) : 32'h3000);
         tick();
      end
      check("fp_empty", occupancy, 0);
      // wrap-around against a queue model
      do_reset();
      drops = 0;
      for (int i = 0; i < 40; i++) begin
         rdy = (i % 2) == 0;
         out_ready = rdy; in_valid = 1; in_pc = 32'h4000 + 32'(4 * i);
         check("wrap_valid", out_valid, q.size() != 0);
         popped = 0;
         if (q.size() != 0 && rdy) begin
            check("wrap_pc", out_record.pc, q[0]);
            popped = 1;
         end
         if (q.size() < 16 || popped) q.push_back(in_pc);
         else drops++;
         if (popped) void'(q.pop_front());
         tick();
      end
      in_valid = 0; out_ready = 1;
      for (int k = 0; k < 20 && q.size() != 0; k++) begin
         check("wrap_drain_pc", out_record.pc, q.pop_front());
         tick();
      end
      check("wrap_empty", out_valid, 0);
      check("wrap_drop", drop_count, 16'(drops));
      // reset mid-stream with in_valid high during reset
      do_reset();
      out_ready = 0;
      push_n(20, 32'h5000);
      out_ready = 1;
      for (int k = 0; k < 9; k++) tick();
      out_ready = 0;
      check("mid_occ_pre", occupancy, 7);
      check("mid_ovf_pre", overflow, 1);
      in_valid = 1; in_pc = 32'h6000;
      do_reset();
      in_valid = 0;
      check("mid_occ", occupancy, 0);
      check("mid_valid", out_valid, 0);
      check("mid_ovf", overflow, 0);
      check("mid_drop", drop_count, 0);
      check("mid_rec", out_record, 0);
      push_n(1, 32'h7000);
      check("mid_push_occ", occupancy, 1);
      check("mid_push_pc", out_record.pc, 32'h7000);
`ifdef RETIRE_TRACE_SEQ_EN
      check("mid_seq", out_record.seq, 0);
      // saturation and seq gaps
      do_reset();
      out_ready = 0;
      push_n(16, 32'h8000);
      in_valid = 1;
      for (int i = 0; i < 65540; i++) tick();
      check("sat_drop", drop_count, 16'hFFFF);
      check("sat_ovf", overflow, 1);
      check("sat_head_seq", out_record.seq, 0);
      out_ready = 1; in_pc = 32'h9000;
      tick();
      in_valid = 0;
      for (int k = 0; k < 16; k++) begin
         check("sat_seq", out_record.seq, (k < 15) ? 32'(k + 1) : 32'd65556);
         tick();
      end
      check("sat_empty", out_valid, 0);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
